// File: rtl/multicycle_main_controller_if.sv
// Control/status bundle between the multi-cycle main controller and the
// RV32I datapath.
//   master : controller side (receives IR fields and ALU flags, drives strobes)
//   slave  : datapath side (drives IR fields and ALU flags, receives strobes)
// Signals:
//   opcode, func3        IR[6:0], IR[14:12]
//   zero, neg            ALU result == 0, ALU result sign bit
//   memReady             memory completes the current access this cycle
//   PCWrite .. RegWrite  datapath strobes and mux selects
//   illegal              sticky illegal-opcode flag
//   state_dbg            current controller state encoding
interface multicycle_main_controller_if #(
  parameter int STATE_W = 4
);
  logic [6:0]         opcode;
  logic [2:0]         func3;
  logic               zero;
  logic               neg;
  logic               memReady;
  logic               PCWrite;
  logic               AdrSrc;
  logic               MemWrite;
  logic               IRWrite;
  logic [1:0]         ResultSrc;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ALUOp;
  logic [2:0]         ImmSrc;
  logic               RegWrite;
  logic               illegal;
  logic [STATE_W-1:0] state_dbg;

  modport master (
    input  opcode, func3, zero, neg, memReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUOp, ImmSrc, RegWrite, illegal, state_dbg
  );

  modport slave (
    output opcode, func3, zero, neg, memReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUOp, ImmSrc, RegWrite, illegal, state_dbg
  );
endinterface

// File: rtl/multicycle_main_controller.sv
// Main control FSM of the multi-cycle RV32I core. Sequences the shared ALU,
// PC, IR and unified memory over 3-5 cycles per instruction (plus one cycle
// per memReady=0 cycle in FETCH / MEMREAD / MEMWRITE).
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous reset, active-high; forces FETCH and clears illegal
//   bus  controller side of multicycle_main_controller_if
//
// state    | meaning
// ---------+------------------------------------------------------------
// FETCH    | read instr at PC, PC <= PC+4 and latch IR when memReady
// DECODE   | ALUOut <= OldPC + imm (branch/jal target), dispatch
// MEMADR   | ALUOut <= rs1 + imm (load/store address)
// MEMREAD  | read data memory at ALUOut, wait for memReady
// MEMWB    | rd <= loaded data
// MEMWRITE | write data memory at ALUOut, strobe held until memReady
// EXECR    | ALUOut <= rs1 op rs2
// EXECI    | ALUOut <= rs1 op imm
// ALUWB    | rd <= ALUOut
// BRANCH   | compare rs1/rs2, PC <= ALUOut when taken
// JAL      | PC <= ALUOut (OldPC+imm), compute link next
// JALR     | PC <= rs1 + imm straight from the ALU
// LINK     | ALUOut <= OldPC + 4
// LUI      | rd <= ImmExt
// ILLEGAL  | unknown opcode, parked until reset
module multicycle_main_controller #(
  parameter int STATE_W = 4
) (
  input logic                      clk,
  input logic                      rst,
  multicycle_main_controller_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    LINK     = 4'd12,
    LUI      = 4'd13,
    ILLEGAL  = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  state_t state;
  state_t state_next;
  logic   branch_taken;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  // next-state logic
  always_comb begin
    state_next = state;
    case (state)
      FETCH:    if (bus.memReady) state_next = DECODE;
      DECODE: begin
        case (bus.opcode)
          OP_LOAD,
          OP_STORE:  state_next = MEMADR;
          OP_RTYPE:  state_next = EXECR;
          OP_ITYPE:  state_next = EXECI;
          OP_BRANCH: state_next = BRANCH;
          OP_JAL:    state_next = JAL;
          OP_JALR:   state_next = JALR;
          OP_LUI:    state_next = LUI;
          default:   state_next = ILLEGAL;
        endcase
      end
      MEMADR:   state_next = (bus.opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (bus.memReady) state_next = MEMWB;
      MEMWB:    state_next = FETCH;
      MEMWRITE: if (bus.memReady) state_next = FETCH;
      EXECR:    state_next = ALUWB;
      EXECI:    state_next = ALUWB;
      ALUWB:    state_next = FETCH;
      BRANCH:   state_next = FETCH;
      JAL:      state_next = ALUWB;
      JALR:     state_next = LINK;
      LINK:     state_next = ALUWB;
      LUI:      state_next = FETCH;
      ILLEGAL:  state_next = ILLEGAL;
      default:  state_next = FETCH;
    endcase
  end

  // blt/bge use the sign of rs1-rs2 as the less-than result
  always_comb begin
    case (bus.func3)
      3'b000:  branch_taken = bus.zero;
      3'b001:  branch_taken = ~bus.zero;
      3'b100:  branch_taken = bus.neg;
      3'b101:  branch_taken = ~bus.neg;
      default: branch_taken = 1'b0;
    endcase
  end

  // output decode
  always_comb begin
    bus.PCWrite   = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.ResultSrc = 2'b00;
    bus.ALUSrcA   = 2'b00;
    bus.ALUSrcB   = 2'b00;
    bus.ALUOp     = 2'b00;
    bus.RegWrite  = 1'b0;
    bus.illegal   = 1'b0;
    case (state)
      FETCH: begin
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        // PC+4 and IR are only committed in the cycle the fetch completes
        bus.IRWrite   = bus.memReady;
        bus.PCWrite   = bus.memReady;
      end
      DECODE: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
      end
      MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
      end
      MEMREAD: bus.AdrSrc = 1'b1;
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = 1'b1;
      end
      EXECR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUOp   = 2'b10;
      end
      EXECI: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        bus.ALUOp   = 2'b11;
      end
      ALUWB: bus.RegWrite = 1'b1;
      BRANCH: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUOp   = 2'b01;
        bus.PCWrite = branch_taken;
      end
      JAL: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        bus.PCWrite = 1'b1;
      end
      JALR: begin
        bus.ALUSrcA   = 2'b10;
        bus.ALUSrcB   = 2'b01;
        bus.ResultSrc = 2'b10;
        bus.PCWrite   = 1'b1;
      end
      LINK: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
      end
      LUI: begin
        bus.ResultSrc = 2'b11;
        bus.RegWrite  = 1'b1;
      end
      // ILLEGAL is only left through reset, so decoding the flag from the
      // state keeps it sticky without a separate register
      ILLEGAL: bus.illegal = 1'b1;
      default: ;
    endcase
  end

  // immediate format follows the opcode in every state
  always_comb begin
    case (bus.opcode)
      OP_STORE:  bus.ImmSrc = 3'b001;
      OP_BRANCH: bus.ImmSrc = 3'b010;
      OP_JAL:    bus.ImmSrc = 3'b011;
      OP_LUI:    bus.ImmSrc = 3'b100;
      default:   bus.ImmSrc = 3'b000;
    endcase
  end

  assign bus.state_dbg = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_main_controller.sv
module tb_multicycle_main_controller;

  localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,
                         S_MEMREAD = 4'd3, S_MEMWB = 4'd4,  S_MEMWRITE = 4'd5,
                         S_EXECR = 4'd6,  S_EXECI = 4'd7,   S_ALUWB = 4'd8,
                         S_BRANCH = 4'd9, S_JAL = 4'd10,    S_JALR = 4'd11,
                         S_LINK = 4'd12,  S_LUI = 4'd13,    S_ILLEGAL = 4'd14;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic [1:0] res;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] aluop;
    logic [2:0] imm;
    logic       regw;
    logic       ill;
  } ctrl_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  ctrl_t q_exp[$];
  string q_name[$];
  logic [2:0] exp_imm;

  multicycle_main_controller_if #(.STATE_W(4)) bus ();

  multicycle_main_controller #(.STATE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // one expected cycle: state plus the data-dependent strobes given by hand,
  // the fixed per-state mux settings filled in from the state table
  task automatic cyc(input logic mr, input logic [3:0] st, input logic pcw,
                     input logic irw, input string nm);
    ctrl_t e;
    e = '0;
    e.st = st; e.pcw = pcw; e.irw = irw; e.imm = exp_imm;
    case (st)
      S_FETCH:    begin e.srcb = 2'b10; e.res = 2'b10; end
      S_DECODE:   begin e.srca = 2'b01; e.srcb = 2'b01; end
      S_MEMADR:   begin e.srca = 2'b10; e.srcb = 2'b01; end
      S_MEMREAD:  e.adr = 1'b1;
      S_MEMWB:    begin e.res = 2'b01; e.regw = 1'b1; end
      S_MEMWRITE: begin e.adr = 1'b1; e.memw = 1'b1; end
      S_EXECR:    begin e.srca = 2'b10; e.aluop = 2'b10; end
      S_EXECI:    begin e.srca = 2'b10; e.srcb = 2'b01; e.aluop = 2'b11; end
      S_ALUWB:    e.regw = 1'b1;
      S_BRANCH:   begin e.srca = 2'b10; e.aluop = 2'b01; end
      S_JAL:      begin e.srca = 2'b01; e.srcb = 2'b10; end
      S_JALR:     begin e.srca = 2'b10; e.srcb = 2'b01; e.res = 2'b10; end
      S_LINK:     begin e.srca = 2'b01; e.srcb = 2'b10; end
      S_LUI:      begin e.res = 2'b11; e.regw = 1'b1; end
      S_ILLEGAL:  e.ill = 1'b1;
      default: ;
    endcase
    bus.memReady = mr;
    q_exp.push_back(e);
    q_name.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic z, input logic n, input logic [2:0] imm);
    bus.opcode = op; bus.func3 = f3; bus.zero = z; bus.neg = n;
    exp_imm = imm;
  endtask

  // monitor: compares the DUT against each queued expectation mid-cycle
  initial begin
    ctrl_t a, e;
    string nm;
    forever begin
      @(negedge clk);
      if (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        nm = q_name.pop_front();
        a.st = bus.state_dbg; a.pcw = bus.PCWrite; a.adr = bus.AdrSrc;
        a.memw = bus.MemWrite; a.irw = bus.IRWrite; a.res = bus.ResultSrc;
        a.srca = bus.ALUSrcA; a.srcb = bus.ALUSrcB; a.aluop = bus.ALUOp;
        a.imm = bus.ImmSrc; a.regw = bus.RegWrite; a.ill = bus.illegal;
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s: got st=%0d pcw=%b adr=%b mw=%b irw=%b res=%b a=%b b=%b op=%b imm=%b rw=%b ill=%b, expected st=%0d pcw=%b adr=%b mw=%b irw=%b res=%b a=%b b=%b op=%b imm=%b rw=%b ill=%b",
                   nm, a.st, a.pcw, a.adr, a.memw, a.irw, a.res, a.srca, a.srcb, a.aluop, a.imm, a.regw, a.ill,
                   e.st, e.pcw, e.adr, e.memw, e.irw, e.res, e.srca, e.srcb, e.aluop, e.imm, e.regw, e.ill);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.memReady = 1'b0;
    set_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // add
    cyc(1, S_FETCH,  1, 1, "add_fetch");
    cyc(1, S_DECODE, 0, 0, "add_decode");
    cyc(1, S_EXECR,  0, 0, "add_execr");
    cyc(1, S_ALUWB,  0, 0, "add_aluwb");

    // lw with 3 stall cycles in MEMREAD
    set_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 3'b000);
    cyc(1, S_FETCH,   1, 1, "lw_fetch");
    cyc(1, S_DECODE,  0, 0, "lw_decode");
    cyc(1, S_MEMADR,  0, 0, "lw_memadr");
    cyc(0, S_MEMREAD, 0, 0, "lw_memread_wait0");
    cyc(0, S_MEMREAD, 0, 0, "lw_memread_wait1");
    cyc(0, S_MEMREAD, 0, 0, "lw_memread_wait2");
    cyc(1, S_MEMREAD, 0, 0, "lw_memread_done");
    cyc(1, S_MEMWB,   0, 0, "lw_memwb");

    // sw with 2 stall cycles in MEMWRITE
    set_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 3'b001);
    cyc(1, S_FETCH,    1, 1, "sw_fetch");
    cyc(1, S_DECODE,   0, 0, "sw_decode");
    cyc(1, S_MEMADR,   0, 0, "sw_memadr");
    cyc(0, S_MEMWRITE, 0, 0, "sw_memwrite_wait0");
    cyc(0, S_MEMWRITE, 0, 0, "sw_memwrite_wait1");
    cyc(1, S_MEMWRITE, 0, 0, "sw_memwrite_done");

    // branches: {func3, zero, neg, taken}
    begin
      logic [5:0] br_tab [6];
      logic [5:0] v;
      br_tab[0] = {3'b000, 1'b1, 1'b0, 1'b1};  // beq zero=1
      br_tab[1] = {3'b001, 1'b1, 1'b0, 1'b0};  // bne zero=1
      br_tab[2] = {3'b001, 1'b0, 1'b0, 1'b1};  // bne zero=0
      br_tab[3] = {3'b100, 1'b0, 1'b1, 1'b1};  // blt neg=1
      br_tab[4] = {3'b101, 1'b0, 1'b1, 1'b0};  // bge neg=1
      br_tab[5] = {3'b010, 1'b1, 1'b1, 1'b0};  // reserved func3
      for (int i = 0; i < 6; i++) begin
        v = br_tab[i];
        set_instr(7'b1100011, v[5:3], v[2], v[1], 3'b010);
        cyc(1, S_FETCH,  1, 1, $sformatf("br%0d_fetch", i));
        cyc(1, S_DECODE, 0, 0, $sformatf("br%0d_decode", i));
        cyc(1, S_BRANCH, v[0], 0, $sformatf("br%0d_branch", i));
      end
    end

    // lui with one fetch stall
    set_instr(7'b0110111, 3'b000, 1'b0, 1'b0, 3'b100);
    cyc(0, S_FETCH,  0, 0, "lui_fetch_wait");
    cyc(1, S_FETCH,  1, 1, "lui_fetch");
    cyc(1, S_DECODE, 0, 0, "lui_decode");
    cyc(1, S_LUI,    0, 0, "lui_wb");

    // jal
    set_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 3'b011);
    cyc(1, S_FETCH,  1, 1, "jal_fetch");
    cyc(1, S_DECODE, 0, 0, "jal_decode");
    cyc(1, S_JAL,    1, 0, "jal_jump");
    cyc(1, S_ALUWB,  0, 0, "jal_aluwb");

    // addi
    set_instr(7'b0010011, 3'b000, 1'b0, 1'b0, 3'b000);
    cyc(1, S_FETCH,  1, 1, "addi_fetch");
    cyc(1, S_DECODE, 0, 0, "addi_decode");
    cyc(1, S_EXECI,  0, 0, "addi_execi");
    cyc(1, S_ALUWB,  0, 0, "addi_aluwb");

    // jalr
    set_instr(7'b1100111, 3'b000, 1'b0, 1'b0, 3'b000);
    cyc(1, S_FETCH,  1, 1, "jalr_fetch");
    cyc(1, S_DECODE, 0, 0, "jalr_decode");
    cyc(1, S_JALR,   1, 0, "jalr_jump");
    cyc(1, S_LINK,   0, 0, "jalr_link");
    cyc(1, S_ALUWB,  0, 0, "jalr_aluwb");

    // reset for two cycles in the middle of EXECR
    set_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 3'b000);
    cyc(1, S_FETCH,  1, 1, "rst_add_fetch");
    cyc(1, S_DECODE, 0, 0, "rst_add_decode");
    rst = 1'b1;
    cyc(0, S_EXECR,  0, 0, "rst_in_execr");
    cyc(0, S_FETCH,  0, 0, "rst_held_fetch");
    rst = 1'b0;
    cyc(1, S_FETCH,  1, 1, "rst_release_fetch");
    cyc(1, S_DECODE, 0, 0, "rst_release_decode");
    cyc(1, S_EXECR,  0, 0, "rst_release_execr");
    cyc(1, S_ALUWB,  0, 0, "rst_release_aluwb");

    // illegal opcode: parked with illegal=1, memReady ignored, reset escapes
    set_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 3'b000);
    cyc(1, S_FETCH,  1, 1, "ill_fetch");
    cyc(1, S_DECODE, 0, 0, "ill_decode");
    for (int i = 0; i < 10; i++)
      cyc(logic'(i % 2), S_ILLEGAL, 0, 0, $sformatf("ill_hold%0d", i));
    rst = 1'b1;
    cyc(1, S_ILLEGAL, 0, 0, "ill_rst_cycle");
    rst = 1'b0;
    set_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 3'b000);
    cyc(0, S_FETCH,  0, 0, "ill_after_rst");

    @(negedge clk);
    #1;
    checks++;
    if (q_exp.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q_exp.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_main_controller.md
Name: multicycle_main_controller

Overview:
Main control FSM for the multi-cycle RV32I core (lw, sw, R-type, I-type ALU, beq/bne/blt/bge, jal, jalr, lui).
- Sequences the shared ALU, the PC, the IR and the unified instruction/data memory over 3–5 cycles per instruction.
- Drives the 2-bit ALUOp consumed by the existing ALU operation decoder: 00 store/add, 01 branch/sub, 10 R-type, 11 I-type.
- Waits on a memory-ready handshake and flags illegal opcodes.

Parameters:
STATE_W, 4, width of the state register and of the debug state output

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  synchronous reset, active-high
opcode  input  7  IR[6:0]
func3  input  3  IR[14:12], branch condition select
zero  input  1  ALU result == 0
neg  input  1  ALU result sign bit (SLT-style compare for blt/bge)
memReady  input  1  memory completes the current access this cycle
PCWrite  output  1  load PC from Result
AdrSrc  output  1  memory address: 0 = PC, 1 = ALUOut
MemWrite  output  1  memory write strobe
IRWrite  output  1  latch IR and OldPC
ResultSrc  output  2  00 ALUOut, 01 mem data, 10 ALU result (unregistered), 11 ImmExt
ALUSrcA  output  2  00 PC, 01 OldPC, 10 reg A
ALUSrcB  output  2  00 reg B, 01 ImmExt, 10 constant 4
ALUOp  output  2  to the ALU operation decoder
ImmSrc  output  3  000 I, 001 S, 010 B, 011 J, 100 U
RegWrite  output  1  register file write enable
illegal  output  1  sticky illegal-opcode flag
state_dbg  output  STATE_W  current state encoding

Behaviour:
- Moore FSM. Outputs are decoded from the state only. Exceptions: PCWrite in BRANCH, and the memReady gating listed below.
- ImmSrc is combinational from opcode in every state. Unknown opcode gives 000.
- Reset (rst=1 at a clock edge, including mid-instruction) forces state FETCH and clears illegal. All strobes are 0 in every state except where listed.
- Default mux outputs in states that do not set them: ALUOp=00, ResultSrc=00, ALUSrcA=00, ALUSrcB=00, AdrSrc=0.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite and PCWrite are asserted only in the cycle memReady=1, then go to DECODE.
  - Otherwise stay in FETCH with all strobes 0.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jal target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - anything else → ILLEGAL
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next MEMREAD if opcode=0000011, else MEMWRITE.
- MEMREAD: AdrSrc=1. Wait for memReady=1, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: AdrSrc=1, MemWrite held high until and including the memReady=1 cycle, then FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=11, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00. Then FETCH.
  - PCWrite = (func3=000 & zero) | (001 & ~zero) | (100 & neg) | (101 & ~neg).
  - Any other func3: PCWrite=0.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1 (PC ← OldPC+imm). Then ALUWB, which writes OldPC+4.
- JALR: ALUSrcA=10, ALUSrcB=01, ALUOp=00, ResultSrc=10, PCWrite=1. Then LINK.
- LINK: ALUSrcA=01, ALUSrcB=10, ALUOp=00, then ALUWB.
- LUI: ResultSrc=11, RegWrite=1, then FETCH.
- ILLEGAL: illegal=1, all strobes 0, state held until rst. memReady is ignored.
- Latency with memReady tied high:
  - R/I/jal: 4 cycles; lui: 3; branch: 3.
  - lw: 5; sw: 4; jalr: 5.
  - Each memReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.

Test Plan:
- Reset: rst=1 for 2 cycles mid-EXECR, then memReady=1 → state=FETCH, IRWrite=1 and PCWrite=1 in the first cycle after release, illegal=0.
- add (opcode 0110011, memReady=1) → FETCH, DECODE, EXECR with ALUOp=10 and ALUSrcB=00, ALUWB with RegWrite=1 exactly once; next FETCH on cycle 5.
- lw with memReady low 3 cycles in MEMREAD → AdrSrc=1 throughout, RegWrite=1 with ResultSrc=01 only in the single MEMWB cycle; 8 cycles total.
- sw, memReady=0 for 2 cycles in MEMWRITE → MemWrite high for 3 consecutive cycles, RegWrite never 1.
- Branches: beq zero=1 → PCWrite=1, ALUOp=01; bne zero=1 → PCWrite=0; blt neg=1 → 1; bge neg=1 → 0; func3=010 → 0.
- jalr → PCWrite=1 with ResultSrc=10 in JALR, then LINK, then RegWrite=1 in ALUWB. Opcode 1111111 → illegal=1 held for 10 cycles; rst returns to FETCH.
